// File: rtl/imem_pkg.sv
// Shared constants and the response-queue entry type for the instruction fetch unit.
package imem_pkg;

  localparam int IMEM_ADDR_W = 32;
  localparam int IMEM_DATA_W = 32;

  localparam logic [IMEM_DATA_W-1:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [1:0]             ERR_NONE     = 2'b00;
  localparam logic [1:0]             ERR_MISALIGN = 2'b01;
  localparam logic [1:0]             ERR_RANGE    = 2'b10;

  typedef struct packed {
    logic [IMEM_DATA_W-1:0] instr;
    logic [IMEM_ADDR_W-1:0] pc;
    logic [1:0]             err;
  } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// QDEPTH-entry response queue; the head entry is a register read, flush empties it in one edge.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int CNT_W  = $clog2(QDEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  imem_rsp_t        push_data,
  input  logic             pop,
  output imem_rsp_t        head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  imem_rsp_t        mem [QDEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Wraps explicitly so non-power-of-two depths behave.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction ROM with registered read, valid/ready handshakes, fault tagging and flush.
// Build option IMEM_WR_PORT_EN adds a program-load write port (wr_en/wr_addr/wr_data).
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int    ADDR_W    = IMEM_ADDR_W,
  parameter int    DATA_W    = IMEM_DATA_W,
  parameter int    DEPTH     = 64,
  parameter int    QDEPTH    = 2,
  parameter string INIT_FILE = "input_text.txt"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_pc,
  output logic [1:0]        rsp_err
`ifdef IMEM_WR_PORT_EN
  ,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
`endif
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W   = $clog2(QDEPTH + 1);
  localparam logic [ADDR_W-3:0] DEPTH_L = (ADDR_W-2)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              pop;
  logic              misalign_p0;
  logic              range_p0;
  logic              rd_en_p0;
  logic [1:0]        err_p0;
  logic [CNT_W:0]    occ;
  logic [CNT_W-1:0]  count;
  logic              vld_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic [1:0]        err_p1;
  logic [DATA_W-1:0] raw_p1;
  imem_rsp_t         push_data;
  imem_rsp_t         head;

  // ROM image is set once at elaboration; reset never touches it.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // p0: request decode and admission
  assign misalign_p0 = (req_pc[1:0] != 2'b00);
  assign range_p0    = (req_pc[ADDR_W-1:2] >= DEPTH_L);

  always_comb begin
    err_p0 = ERR_NONE;
    if (misalign_p0)   err_p0 = ERR_MISALIGN;
    else if (range_p0) err_p0 = ERR_RANGE;
  end

  assign pop       = rsp_valid && rsp_ready;
  assign occ       = {1'b0, count} + (CNT_W+1)'(vld_p1) - (CNT_W+1)'(pop);
  assign req_ready = !flush && (occ < (CNT_W+1)'(QDEPTH));
  assign accept    = req_valid && req_ready;
  assign rd_en_p0  = accept && (err_p0 == ERR_NONE);

`ifdef IMEM_WR_PORT_EN
  logic             wr_ok;
  logic [IDX_W-1:0] wr_idx;

  assign wr_ok  = wr_en && (wr_addr[1:0] == 2'b00) && (wr_addr[ADDR_W-1:2] < DEPTH_L);
  assign wr_idx = wr_addr[IDX_W+1:2];
`endif

  // p1: ROM read; read and write share one block so a same-index read sees old data
  always_ff @(posedge clk) begin
`ifdef IMEM_WR_PORT_EN
    if (wr_ok) mem[wr_idx] <= wr_data;
`endif
    if (rd_en_p0) raw_p1 <= mem[req_pc[IDX_W+1:2]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      pc_p1  <= '0;
      err_p1 <= ERR_NONE;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        pc_p1  <= req_pc;
        err_p1 <= err_p0;
      end
    end
  end

  // p2: response queue, head drives the outputs
  always_comb begin
    push_data.instr = (err_p1 == ERR_NONE) ? IMEM_DATA_W'(raw_p1) : NOP_INSTR;
    push_data.pc    = IMEM_ADDR_W'(pc_p1);
    push_data.err   = err_p1;
  end

  imem_rsp_fifo #(
    .QDEPTH (QDEPTH),
    .CNT_W  (CNT_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (vld_p1),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign rsp_valid = (count != '0);
  assign rsp_instr = DATA_W'(head.instr);
  assign rsp_pc    = ADDR_W'(head.pc);
  assign rsp_err   = head.err;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: ordered-queue model checked every cycle plus literal spot checks.
module tb_imem_fetch_unit;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int QD    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_pc;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_instr;
  logic [AW-1:0] rsp_pc;
  logic [1:0]    rsp_err;
`ifdef IMEM_WR_PORT_EN
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
`endif

  always #5 clk = ~clk;

  imem_fetch_unit #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .QDEPTH    (QD),
    .INIT_FILE ("")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_pc    (rsp_pc),
    .rsp_err   (rsp_err)
`ifdef IMEM_WR_PORT_EN
    ,
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  err;
    int          cyc;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        got_q[$];
  logic [31:0] exp_mem [DEPTH];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // What a request at this pc must return, straight from the fault rules.
  function automatic ent_t predict(input logic [31:0] pc, input int c);
    ent_t e;
    e.pc  = pc;
    e.cyc = c;
    if (pc[1:0] != 2'b00) begin
      e.err = 2'b01; e.instr = 32'h0;
    end else if (pc[31:2] >= 30'(DEPTH)) begin
      e.err = 2'b10; e.instr = 32'h0;
    end else begin
      e.err = 2'b00; e.instr = exp_mem[pc[7:2]];
    end
    return e;
  endfunction

  initial begin : compare
    logic ev, er, pop_e, acc_e;
    int   occ;
    ent_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_instr", rsp_instr, 0);
        chk("reset_rsp_pc",    rsp_pc,    0);
        chk("reset_rsp_err",   rsp_err,   0);
      end else begin
        ev    = (exp_q.size() > 0) && (cyc >= exp_q[0].cyc + 2);
        pop_e = ev && rsp_ready;
        occ   = exp_q.size() - (pop_e ? 1 : 0);
        er    = !flush && (occ < QD);
        chk("req_ready", req_ready, er);
        chk("rsp_valid", rsp_valid, ev);
        if (ev) begin
          chk("rsp_instr", rsp_instr, exp_q[0].instr);
          chk("rsp_pc",    rsp_pc,    exp_q[0].pc);
          chk("rsp_err",   rsp_err,   exp_q[0].err);
        end
        if (pop_e) begin
          e.instr = rsp_instr; e.pc = rsp_pc; e.err = rsp_err; e.cyc = cyc;
          got_q.push_back(e);
          void'(exp_q.pop_front());
        end
        acc_e = req_valid && er;
        if (flush) exp_q.delete();
        else if (acc_e) exp_q.push_back(predict(req_pc, cyc));
`ifdef IMEM_WR_PORT_EN
        if (wr_en && wr_addr[1:0] == 2'b00 && wr_addr[31:2] < 30'(DEPTH))
          exp_mem[wr_addr[7:2]] = wr_data;
`endif
      end
    end
  end

  task automatic send(input logic [31:0] pc);
    bit acc = 1'b0;
    int n   = 0;
    req_valid = 1'b1;
    req_pc    = pc;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = req_ready;
      n++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin : stim
    int n0, c0, acc;
    rst_n = 1'b1; flush = 1'b0; req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b0;
`ifdef IMEM_WR_PORT_EN
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`endif
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      dut.mem[i] = 32'h1000_0000 + 32'(i);
      exp_mem[i] = 32'h1000_0000 + 32'(i);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);
    @(posedge clk); #1;

    // back-to-back stream of words 0..7
    rsp_ready = 1'b1;
    n0 = got_q.size();
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(32'(i * 4));
    chk("stream_no_bubble", cyc - c0, 8);
    drain();
    for (int i = 0; i < 8; i++) begin
      chk("stream_instr", got_q[n0+i].instr, 32'h1000_0000 + 32'(i));
      chk("stream_err",   got_q[n0+i].err,   0);
    end
    chk("stream_latency", got_q[n0].cyc - c0, 3);
    chk("stream_rate",    got_q[n0+7].cyc - got_q[n0].cyc, 7);

    // fault tagging and boundaries
    n0 = got_q.size();
    send(32'h6); send(32'h100); send(32'h8); send(32'hFC); send(32'h103);
    drain();
    chk("fault_mis_err",   got_q[n0].err,     2'b01);
    chk("fault_mis_instr", got_q[n0].instr,   32'h0);
    chk("fault_mis_pc",    got_q[n0].pc,      32'h6);
    chk("fault_rng_err",   got_q[n0+1].err,   2'b10);
    chk("fault_rng_instr", got_q[n0+1].instr, 32'h0);
    chk("fault_ok_err",    got_q[n0+2].err,   2'b00);
    chk("fault_ok_instr",  got_q[n0+2].instr, 32'h1000_0002);
    chk("last_word_instr", got_q[n0+3].instr, 32'h1000_003F);
    chk("mis_priority",    got_q[n0+4].err,   2'b01);

    // backpressure
    rsp_ready = 1'b0;
    acc = 0;
    n0 = got_q.size();
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1;
      req_pc    = 32'h40 + 32'(acc * 4);
      @(negedge clk);
      if (k == 4) chk("bp_ready_low", req_ready, 0);
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("bp_accepted", acc, 2);
    rsp_ready = 1'b1;
    for (int k = acc; k < 6; k++) send(32'h40 + 32'(k * 4));
    drain();
    chk("bp_count", got_q.size() - n0, 6);
    for (int k = 0; k < 6; k++) chk("bp_order", got_q[n0+k].pc, 32'h40 + 32'(k * 4));

    // flush with one queued and one in flight
    rsp_ready = 1'b0;
    send(32'h0); send(32'h4);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_valid_before_edge", rsp_valid, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_cleared", rsp_valid, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    n0 = got_q.size();
    send(32'h10);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("flush_only_one", got_q.size() - n0, 1);
    chk("flush_next_instr", got_q[n0].instr, 32'h1000_0004);

    // reset in the middle of traffic
    rsp_ready = 1'b0;
    send(32'h8); send(32'hC);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_instr", rsp_instr, 0);
    chk("midrst_pc",    rsp_pc,    0);
    chk("midrst_err",   rsp_err,   0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", req_ready, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    n0 = got_q.size();
    send(32'h14);
    drain();
    chk("midrst_resume", got_q[n0].instr, 32'h1000_0005);

`ifdef IMEM_WR_PORT_EN
    n0 = got_q.size();
    wr_en = 1'b1; wr_addr = 32'h20; wr_data = 32'hDEAD_BEEF;
    send(32'h20);
    wr_en = 1'b0;
    send(32'h20);
    wr_en = 1'b1; wr_addr = 32'h21; wr_data = 32'h1234_5678;
    send(32'h24);
    wr_addr = 32'h100; wr_data = 32'h0000_0055;
    send(32'h28);
    wr_en = 1'b0;
    send(32'h20);
    send(32'h0);
    drain();
    chk("wr_same_cycle_old", got_q[n0].instr,   32'h1000_0008);
    chk("wr_reread_new",     got_q[n0+1].instr, 32'hDEAD_BEEF);
    chk("wr_read_9",         got_q[n0+2].instr, 32'h1000_0009);
    chk("wr_read_10",        got_q[n0+3].instr, 32'h1000_000A);
    chk("wr_misalign_ign",   got_q[n0+4].instr, 32'hDEAD_BEEF);
    chk("wr_range_ign",      got_q[n0+5].instr, 32'h1000_0000);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

endmodule
